buzzer_scheduler: RTL and testbench
===================================

// Module: buzzer_scheduler
// PURPOSE
//  Shares the single piezo buzzer between up to four alert sources (mic echo, hunger, sleep, health).
//  Arbitrates requests with fixed priority, then sequences a beep burst for the winner.
//  Each burst is N on/off beeps at a per-requester tone rate, followed by a silent gap.
//  Sits between the state/sensor blocks and the buzzer pin; it replaces direct buzzer drive by requesters.
// PARAMETERS
//  COUNT_MAX   25000000  base period in clk cycles; half-period per beep = COUNT_MAX/div
//  GAP_CYCLES  12500000  silent cycles appended after the last beep of a burst (>=1)
// PORTS
//  clk       in   1   system clock
//  rst       in   1   synchronous reset, active-high
//  req       in   4   request lines; bit0 highest priority; level, held until done or abort
//  beeps_i   in   12  {r3,r2,r1,r0} 3-bit beep count per requester; 0 treated as 1
//  div_i     in   12  {r3,r2,r1,r0} 3-bit tone divisor per requester; 0 treated as 1
//  enable    in   1   0 = no new grants (burst in progress completes)
//  buzzer    out  1   active-low buzzer drive (0 = sounding)
//  busy      out  1   1 while any grant is held
//  grant     out  4   one-hot owner of the buzzer
//  done      out  4   one-hot, one-cycle pulse at normal burst completion
// BEHAVIOUR
//  Reset (rst=1 at posedge): state IDLE, buzzer=1, busy=0, grant=0, done=0, counters=0. Applies mid-burst, no done pulse.
//  All outputs registered. Single FSM: IDLE, LOAD, ON, OFF, GAP, DONE.
//  IDLE: buzzer=1. If enable && |req: grant <= lowest set index, busy<=1, latch beeps/div of winner -> LOAD.
//  LOAD (1 cycle): half <= COUNT_MAX/div (div 1..7, constant-divide via case), rem <= beeps, cnt <= 0 -> ON.
//  ON: buzzer=0 for exactly half cycles (cnt 0..half-1), then cnt<=0 -> OFF.
//  OFF: buzzer=1 for exactly half cycles; at end rem<=rem-1; if rem==1 -> GAP else -> ON.
//  GAP: buzzer=1 for GAP_CYCLES cycles -> DONE.
//  DONE (1 cycle): done[g]=1, grant<=0, busy<=0 -> IDLE.
//  Latency: req seen at edge k -> grant/busy high after k; buzzer low after k+1.
//  Busy duration = 1 + 2*beeps*half + GAP_CYCLES + 1 cycles.
//  Non-preemptive: higher-priority req arriving mid-burst waits for DONE. Min one IDLE cycle between grants.
//  A req still high in IDLE after its done is re-granted (requester must drop req on done).
//  Abort: granted req bit low in LOAD/ON/OFF/GAP -> next cycle IDLE, buzzer=1, grant=0, busy=0, no done.
//  Priority/selection ignores req bits changing during a burst except the granted bit (abort).
//  enable low never stops a running burst; it only blocks the IDLE grant decision.
//  Counter width $clog2(COUNT_MAX+GAP_CYCLES); half >= 1 guaranteed by COUNT_MAX >= 7.
//  Simultaneous done of burst and new req in same cycle: new grant evaluated in following IDLE cycle.
// TESTING (COUNT_MAX=8, GAP_CYCLES=4)
//  rst 3 cycles -> buzzer=1, busy=0, grant=0, done=0 throughout and after release.
//  req=0001, beeps0=2, div0=2 -> grant=0001 next cycle; buzzer 0x4,1x4,0x4,1x4; 4 gap; done[0] one cycle; busy 22 cycles.
//  req=1010 together -> grant=0010; req[3] granted only after done[1] plus one IDLE cycle.
//  beeps0=0, div0=0 -> treated 1/1: single beep, buzzer low 8 cycles, high 8, gap 4, done[0].
//  Drop req[0] during 2nd ON -> next cycle buzzer=1, grant=0, busy=0, done stays 0.
//  enable=0 with req=0100 -> no grant; enable=1 -> grant=0100 next edge. rst mid-ON -> buzzer=1 next edge, no done.

Source files
------------

// File: rtl/buzzer_scheduler.sv
// Buzzer arbiter and beep-burst sequencer.
// Fixed-priority grant, N beeps at a tone rate, then a silent gap.
module buzzer_scheduler #(
  parameter int COUNT_MAX  = 25000000,
  parameter int GAP_CYCLES = 12500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [11:0] beeps_i,
  input  logic [11:0] div_i,
  input  logic        enable,
  output logic        buzzer,
  output logic        busy,
  output logic [3:0]  grant,
  output logic [3:0]  done
);

  localparam int CW = $clog2(COUNT_MAX + GAP_CYCLES);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t ONE     = cnt_t'(1);
  localparam cnt_t GAP_END = cnt_t'(GAP_CYCLES - 1);
  localparam cnt_t H1      = cnt_t'(COUNT_MAX / 1);
  localparam cnt_t H2      = cnt_t'(COUNT_MAX / 2);
  localparam cnt_t H3      = cnt_t'(COUNT_MAX / 3);
  localparam cnt_t H4      = cnt_t'(COUNT_MAX / 4);
  localparam cnt_t H5      = cnt_t'(COUNT_MAX / 5);
  localparam cnt_t H6      = cnt_t'(COUNT_MAX / 6);
  localparam cnt_t H7      = cnt_t'(COUNT_MAX / 7);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ON,
    S_OFF,
    S_GAP,
    S_FIN
  } state_t;

  state_t     state;
  logic [2:0] beeps_l;
  logic [2:0] div_l;
  logic [2:0] rem;
  cnt_t       half;
  cnt_t       cnt;

  logic [3:0] win;
  logic [2:0] sel_b;
  logic [2:0] sel_d;
  cnt_t       half_nx;
  logic       abort;

  // lowest set request bit wins; pick its beep count and divisor
  always_comb begin
    win   = req & (~req + 4'd1);
    sel_b = beeps_i[2:0];
    sel_d = div_i[2:0];
    unique case (1'b1)
      win[0]: begin
        sel_b = beeps_i[2:0];
        sel_d = div_i[2:0];
      end
      win[1]: begin
        sel_b = beeps_i[5:3];
        sel_d = div_i[5:3];
      end
      win[2]: begin
        sel_b = beeps_i[8:6];
        sel_d = div_i[8:6];
      end
      win[3]: begin
        sel_b = beeps_i[11:9];
        sel_d = div_i[11:9];
      end
      default: ;
    endcase
  end

  // half-period lookup: constant divides only
  always_comb begin
    half_nx = H1;
    unique case (div_l)
      3'd1:    half_nx = H1;
      3'd2:    half_nx = H2;
      3'd3:    half_nx = H3;
      3'd4:    half_nx = H4;
      3'd5:    half_nx = H5;
      3'd6:    half_nx = H6;
      3'd7:    half_nx = H7;
      default: half_nx = H1;
    endcase
  end

  // owner dropping its request cancels the burst
  always_comb begin
    abort = (req & grant) == 4'd0;
  end

  // burst sequencer with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      buzzer  <= 1'b1;
      busy    <= 1'b0;
      grant   <= 4'd0;
      done    <= 4'd0;
      beeps_l <= 3'd0;
      div_l   <= 3'd0;
      rem     <= 3'd0;
      half    <= '0;
      cnt     <= '0;
    end else begin
      done <= 4'd0;
      if (state != S_IDLE &&
          state != S_FIN && abort) begin
        state  <= S_IDLE;
        buzzer <= 1'b1;
        grant  <= 4'd0;
        busy   <= 1'b0;
        cnt    <= '0;
      end else begin
        unique case (state)
          S_IDLE: begin
            buzzer <= 1'b1;
            if (enable && |req) begin
              grant   <= win;
              busy    <= 1'b1;
              beeps_l <= (sel_b == 3'd0) ? 3'd1 : sel_b;
              div_l   <= (sel_d == 3'd0) ? 3'd1 : sel_d;
              state   <= S_LOAD;
            end
          end
          S_LOAD: begin
            half   <= half_nx;
            rem    <= beeps_l;
            cnt    <= '0;
            buzzer <= 1'b0;
            state  <= S_ON;
          end
          S_ON: begin
            if (cnt == half - ONE) begin
              cnt    <= '0;
              buzzer <= 1'b1;
              state  <= S_OFF;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          S_OFF: begin
            if (cnt == half - ONE) begin
              cnt <= '0;
              rem <= rem - 3'd1;
              if (rem == 3'd1) begin
                state <= S_GAP;
              end else begin
                buzzer <= 1'b0;
                state  <= S_ON;
              end
            end else begin
              cnt <= cnt + ONE;
            end
          end
          S_GAP: begin
            if (cnt == GAP_END) begin
              cnt   <= '0;
              done  <= grant;
              state <= S_FIN;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          S_FIN: begin
            grant <= 4'd0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_buzzer_scheduler.sv
// Bench for buzzer_scheduler.
// Offset-based burst model plus directed scenarios.
module tb_buzzer_scheduler;

  localparam int CM  = 8;
  localparam int GAP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = 4'd0;
  logic [11:0] beeps_i = 12'd0;
  logic [11:0] div_i = 12'd0;
  logic        enable = 1'b1;
  logic        buzzer;
  logic        busy;
  logic [3:0]  grant;
  logic [3:0]  done;

  int n_pass = 0;
  int n_total = 0;

  buzzer_scheduler #(
    .COUNT_MAX (CM),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .beeps_i(beeps_i),
    .div_i  (div_i),
    .enable (enable),
    .buzzer (buzzer),
    .busy   (busy),
    .grant  (grant),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input int got,
                       input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h @%0t",
                  name, got, exp, $time);
  endtask

  // model: owner index and cycle offset since grant
  int m_own = -1;
  int m_off = 0;
  int m_len = 0;
  int m_h = 1;
  int m_b = 1;
  bit m_ok = 1'b0;

  always @(posedge clk) begin : model
    int w;
    int b;
    int d;
    if (rst) begin
      m_own = -1;
    end else if (m_own >= 0) begin
      if (m_off <= m_len - 2 && !req[m_own]) begin
        m_own = -1;
      end else begin
        m_off++;
        if (m_off == m_len) m_own = -1;
      end
    end else if (enable && req != 4'd0) begin
      w = 0;
      for (int i = 3; i >= 0; i--)
        if (req[i]) w = i;
      b = int'(beeps_i[3*w +: 3]);
      d = int'(div_i[3*w +: 3]);
      if (b == 0) b = 1;
      if (d == 0) d = 1;
      m_own = w;
      m_b = b;
      m_h = CM / d;
      m_len = 2 + 2 * b * m_h + GAP;
      m_off = 0;
    end
    m_ok = 1'b1;
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin : cmp
    int e_bz;
    int e_bs;
    int e_g;
    int e_d;
    int o;
    if (m_ok) begin
      e_bz = 1;
      e_bs = 0;
      e_g = 0;
      e_d = 0;
      if (m_own >= 0) begin
        o = m_off;
        e_bs = 1;
        e_g = 1 << m_own;
        if (o == m_len - 1) e_d = e_g;
        if (o >= 1 && (o - 1) < 2 * m_b * m_h &&
            ((o - 1) / m_h) % 2 == 0)
          e_bz = 0;
      end
      check("cyc_buzzer", int'(buzzer), e_bz);
      check("cyc_busy", int'(busy), e_bs);
      check("cyc_grant", int'(grant), e_g);
      check("cyc_done", int'(done), e_d);
    end
  end

  int n_busy;
  int n_low;
  int n_done;
  int g_first;
  int g_second;
  int i_done;
  int i_g2;

  // observe n cycles; owner drops req on its done
  task automatic run(input int n);
    n_busy = 0;
    n_low = 0;
    n_done = 0;
    g_first = 0;
    g_second = 0;
    i_done = -1;
    i_g2 = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (busy) n_busy++;
      if (!buzzer) n_low++;
      if (done != 4'd0) begin
        n_done++;
        if (i_done < 0) i_done = i;
        req = req & ~done;
      end
      if (grant != 4'd0) begin
        if (g_first == 0) g_first = int'(grant);
        else if (int'(grant) != g_first &&
                 g_second == 0) begin
          g_second = int'(grant);
          i_g2 = i;
        end
      end
    end
  endtask

  task automatic wait_low(input string name);
    int k;
    k = 0;
    while (buzzer !== 1'b0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) check(name, 1, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_buzzer", int'(buzzer), 1);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_grant", int'(grant), 0);

    // two beeps, div 2 -> half 4
    beeps_i = 12'o0002;
    div_i = 12'o0002;
    req = 4'b0001;
    run(30);
    check("t2_grant", g_first, 1);
    check("t2_busy_len", n_busy, 22);
    check("t2_low_len", n_low, 8);
    check("t2_done_cnt", n_done, 1);

    // priority: r1 first, r3 after done + idle
    beeps_i = 12'o1010;
    div_i = 12'o7070;
    req = 4'b1010;
    run(30);
    check("t3_first", g_first, 2);
    check("t3_second", g_second, 8);
    check("t3_idle_gap", i_g2 - i_done, 2);
    check("t3_done_cnt", n_done, 2);
    check("t3_busy_len", n_busy, 16);

    // zero beeps/div behave as one
    beeps_i = 12'o0000;
    div_i = 12'o0000;
    req = 4'b0001;
    run(30);
    check("t4_busy_len", n_busy, 22);
    check("t4_low_len", n_low, 8);
    check("t4_done_cnt", n_done, 1);

    // abort during the second ON phase
    beeps_i = 12'o0003;
    div_i = 12'o0002;
    req = 4'b0001;
    wait_low("t5_to_on1");
    while (buzzer === 1'b0) @(negedge clk);
    wait_low("t5_to_on2");
    req = 4'b0000;
    @(negedge clk);
    check("t5_buzzer", int'(buzzer), 1);
    check("t5_grant", int'(grant), 0);
    check("t5_busy", int'(busy), 0);
    run(10);
    check("t5_no_done", n_done, 0);

    // enable gating, then reset mid-ON
    enable = 1'b0;
    req = 4'b0100;
    run(5);
    check("t6_blocked", g_first, 0);
    check("t6_blk_busy", n_busy, 0);
    enable = 1'b1;
    @(negedge clk);
    check("t6_grant", int'(grant), 4);
    wait_low("t6_to_on");
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_buzzer", int'(buzzer), 1);
    check("t6_rst_grant", int'(grant), 0);
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_done", int'(done), 0);
    rst = 1'b0;
    req = 4'b0000;
    run(5);
    check("t6_no_done", n_done, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
